// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs from decode, imem port and IF/ID outputs.
// Optional IF_STAGE_STATS_EN adds the fetch_count/kill_count statistics signals.
interface if_stage_if;
  logic        stall;
  logic [1:0]  PCSrc;
  logic [15:0] I_TypeImmediate;
  logic [15:0] J_TypeImmediate;
  logic [15:0] ReturnAddress;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] instruction;
  logic [15:0] NPC;
  logic        valid;
  logic        halted;
`ifdef IF_STAGE_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] kill_count;

  modport slave (
    input  stall, PCSrc, I_TypeImmediate, J_TypeImmediate, ReturnAddress, imem_data,
    output imem_addr, instruction, NPC, valid, halted, fetch_count, kill_count
  );
  modport master (
    output stall, PCSrc, I_TypeImmediate, J_TypeImmediate, ReturnAddress, imem_data,
    input  imem_addr, instruction, NPC, valid, halted, fetch_count, kill_count
  );
`else
  modport slave (
    input  stall, PCSrc, I_TypeImmediate, J_TypeImmediate, ReturnAddress, imem_data,
    output imem_addr, instruction, NPC, valid, halted
  );
  modport master (
    output stall, PCSrc, I_TypeImmediate, J_TypeImmediate, ReturnAddress, imem_data,
    input  imem_addr, instruction, NPC, valid, halted
  );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register with stall/kill/halt.
// Optional macro IF_STAGE_STATS_EN adds saturating fetch and kill counters.
module if_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_WORD    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic            clk,
  input  logic            reset,
  if_stage_if.slave       bus,
  output logic [1:0]      o_dbg_state
);

  // Handshake: stall=1 freezes PC and IF/ID; a nonzero PCSrc is honoured only on a
  // RUN cycle with stall=0, so decode must hold PCSrc stable until stall drops.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_npc;
  logic        r_valid;
  logic        r_halted;

  logic [15:0] w_pc_next;
  logic [15:0] w_instr_next;
  logic [15:0] w_npc_next;
  logic        w_valid_next;
  logic        w_halted_next;
  logic [15:0] w_pc_inc;
  logic [15:0] w_target;
  logic        w_fetch;
  logic        w_kill;

  assign w_pc_inc = r_pc + 16'd1;

  always_comb begin
    w_target = w_pc_inc;
    case (bus.PCSrc)
      2'd1:    w_target = bus.I_TypeImmediate;
      2'd2:    w_target = bus.J_TypeImmediate;
      2'd3:    w_target = bus.ReturnAddress;
      default: w_target = w_pc_inc;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc_next     = r_pc;
    w_instr_next  = r_instr;
    w_npc_next    = r_npc;
    w_valid_next  = r_valid;
    w_halted_next = r_halted;
    w_fetch       = 1'b0;
    w_kill        = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_instr_next = NOP_WORD;
        w_npc_next   = 16'd0;
        w_valid_next = 1'b0;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (bus.PCSrc != 2'd0) begin
            // The word fetched alongside the redirect is squashed; no halt check on it.
            w_pc_next    = w_target;
            w_instr_next = NOP_WORD;
            w_npc_next   = 16'd0;
            w_valid_next = 1'b0;
            w_kill       = 1'b1;
          end else begin
            w_instr_next = bus.imem_data;
            w_npc_next   = w_pc_inc;
            w_valid_next = 1'b1;
            w_fetch      = 1'b1;
            if (bus.imem_data[15:12] == HALT_OPCODE) begin
              w_next_state = S_HALT;
            end else begin
              w_pc_next = w_pc_inc;
            end
          end
        end
      end
      S_HALT: begin
        w_instr_next  = NOP_WORD;
        w_valid_next  = 1'b0;
        w_halted_next = 1'b1;
      end
      default: begin
        w_next_state = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_WORD;
      r_npc    <= 16'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pc     <= w_pc_next;
      r_instr  <= w_instr_next;
      r_npc    <= w_npc_next;
      r_valid  <= w_valid_next;
      r_halted <= w_halted_next;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.instruction = r_instr;
  assign bus.NPC         = r_npc;
  assign bus.valid       = r_valid;
  assign bus.halted      = r_halted;
  assign o_dbg_state     = r_state;

`ifdef IF_STAGE_STATS_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_kill_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 16'd0;
      r_kill_count  <= 16'd0;
    end else begin
      if (w_fetch && (r_fetch_count != 16'hFFFF)) r_fetch_count <= r_fetch_count + 16'd1;
      if (w_kill && (r_kill_count != 16'hFFFF))   r_kill_count  <= r_kill_count + 16'd1;
    end
  end

  assign bus.fetch_count = r_fetch_count;
  assign bus.kill_count  = r_kill_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle expected IF/ID and PC values queued, then checked after each edge.
module tb_if_stage;

  localparam int W = 51;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       halt_at_3 = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [W-1:0] exp_q[$];

  if_stage_if bus();

  if_stage u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word = 16'h1000 + addr, with optional HALT at address 3.
  always_comb begin
    if (halt_at_3 && (bus.imem_addr == 16'd3)) bus.imem_data = 16'hF000;
    else                                       bus.imem_data = 16'h1000 + bus.imem_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive controls, queue the expected IF/ID+PC state, compare after the edge.
  task automatic step(input logic s, input logic [1:0] src,
                      input logic [15:0] e_instr, input logic [15:0] e_npc,
                      input logic e_valid, input logic e_halted,
                      input logic [15:0] e_addr, input logic chk_npc);
    logic [W-1:0] e;
    bus.stall = s;
    bus.PCSrc = src;
    exp_q.push_back({e_instr, e_npc, e_valid, e_halted, e_addr, chk_npc});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("instruction", bus.instruction, e[50:35]);
    if (e[0]) chk("NPC", bus.NPC, e[34:19]);
    chk("valid", {15'd0, bus.valid}, {15'd0, e[18]});
    chk("halted", {15'd0, bus.halted}, {15'd0, e[17]});
    chk("imem_addr", bus.imem_addr, e[16:1]);
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.PCSrc = 2'd0;
    bus.I_TypeImmediate = 16'h0040;
    bus.J_TypeImmediate = 16'h0123;
    bus.ReturnAddress   = 16'h0200;

    // Reset held, with activity on the inputs that must be ignored.
    reset = 1'b1;
    step(1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("dbg_state_reset", {14'd0, dbg_state}, 16'd0);
    reset = 1'b0;

    // BOOT cycle ignores stall and PCSrc.
    step(1'b1, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    // Sequential fetch of addresses 0..4.
    for (int a = 0; a < 5; a++)
      step(1'b0, 2'd0, 16'h1000 + 16'(a), 16'(a + 1), 1'b1, 1'b0, 16'(a + 1), 1'b1);

    // PC = 5: stall three cycles, everything holds.
    for (int k = 0; k < 3; k++)
      step(1'b1, 2'd0, 16'h1004, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b1);
    for (int a = 5; a < 8; a++)
      step(1'b0, 2'd0, 16'h1000 + 16'(a), 16'(a + 1), 1'b1, 1'b0, 16'(a + 1), 1'b1);

    // PC = 8: branch, jump and return redirects, each costing one bubble.
    step(1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1);
    step(1'b0, 2'd0, 16'h1040, 16'h0041, 1'b1, 1'b0, 16'h0041, 1'b1);
    step(1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0123, 1'b1);
    step(1'b0, 2'd0, 16'h1123, 16'h0124, 1'b1, 1'b0, 16'h0124, 1'b1);
    step(1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0200, 1'b1);
    step(1'b0, 2'd0, 16'h1200, 16'h0201, 1'b1, 1'b0, 16'h0201, 1'b1);

    // Stall beats redirect; redirect takes effect once stall drops.
    step(1'b1, 2'd1, 16'h1200, 16'h0201, 1'b1, 1'b0, 16'h0201, 1'b1);
    step(1'b1, 2'd1, 16'h1200, 16'h0201, 1'b1, 1'b0, 16'h0201, 1'b1);
    step(1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1);
    step(1'b0, 2'd0, 16'h1040, 16'h0041, 1'b1, 1'b0, 16'h0041, 1'b1);

    // PC wrap: return to 16'hFFFF, then fetch sequentially through 0.
    bus.ReturnAddress = 16'hFFFF;
    step(1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1);
    step(1'b0, 2'd0, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 2'd0, 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1);
    step(1'b0, 2'd0, 16'h1001, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b1);

    // HALT word at address 3: seen once with valid, then fetch freezes.
    halt_at_3 = 1'b1;
    step(1'b0, 2'd0, 16'h1002, 16'h0003, 1'b1, 1'b0, 16'h0003, 1'b1);
    step(1'b0, 2'd0, 16'hF000, 16'h0004, 1'b1, 1'b0, 16'h0003, 1'b1);
    for (int k = 0; k < 10; k++) begin
      bus.I_TypeImmediate = 16'($urandom_range(0, 65535));
      bus.J_TypeImmediate = 16'($urandom_range(0, 65535));
      bus.ReturnAddress   = 16'($urandom_range(0, 65535));
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0);
    end
    chk("dbg_state_halt", {14'd0, dbg_state}, 16'd2);

    // Reset exits HALT even with a redirect pending.
    reset = 1'b1;
    step(1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    reset = 1'b0;
    halt_at_3 = 1'b0;
    bus.I_TypeImmediate = 16'h0040;
    step(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int a = 0; a < 4; a++)
      step(1'b0, 2'd0, 16'h1000 + 16'(a), 16'(a + 1), 1'b1, 1'b0, 16'(a + 1), 1'b1);
    step(1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1);
`ifdef IF_STAGE_STATS_EN
    chk("fetch_count", bus.fetch_count, 16'd4);
    chk("kill_count", bus.kill_count, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC, drives the instruction-memory address and selects the next PC from sequential / branch / jump / return targets.
- Registers the IF/ID pipeline outputs (instruction, NPC) that decode consumes, with stall, kill-on-redirect and halt handling.
- 16-bit word-addressed ISA: one instruction per address, PC increments by 1.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 16'h0000, bubble instruction placed into IF/ID on boot, kill or halt.
- HALT_OPCODE, 4'hF, value of instruction[15:12] that halts fetch.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- PCSrc  input  2  next-PC select: 0 = PC+1, 1 = I_TypeImmediate, 2 = J_TypeImmediate, 3 = ReturnAddress.
- I_TypeImmediate  input  16  branch target from decode.
- J_TypeImmediate  input  16  jump target from decode.
- ReturnAddress  input  16  R7 value from decode.
- imem_data  input  16  instruction memory read data; combinational from imem_addr.
- imem_addr  output  16  equals the PC register.
- instruction  output  16  IF/ID instruction register.
- NPC  output  16  IF/ID next-PC register (fetch PC + 1).
- valid  output  1  IF/ID holds a real (non-bubble) instruction.
- halted  output  1  fetch stopped by a HALT instruction.

Behaviour:
- Reset, synchronous and dominant over all other inputs:
  - PC = RESET_PC, instruction = NOP_WORD, NPC = 0, valid = 0, halted = 0, state = BOOT.
  - Reset asserted mid-operation discards any pending redirect or stall.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset deasserts.
  - PC held; IF/ID loaded with bubble (NOP_WORD, valid = 0).
  - Next state RUN. stall and PCSrc are ignored in this state.
- RUN, stall = 1:
  - PC, instruction, NPC and valid all hold; PCSrc is ignored.
  - Stall has priority over redirect; decode must hold PCSrc until stall drops.
- RUN, stall = 0, PCSrc = 0:
  - instruction <= imem_data; NPC <= PC + 1; valid <= 1; PC <= PC + 1.
  - PC + 1 is mod 2^16, so 16'hFFFF wraps to 16'h0000.
- RUN, stall = 0, PCSrc != 0 (redirect):
  - PC <= selected target.
  - The instruction fetched this cycle is killed: instruction <= NOP_WORD, NPC <= 0, valid <= 0.
  - No halt check is made on a killed word.
- RUN, stall = 0, PCSrc = 0, imem_data[15:12] == HALT_OPCODE:
  - The HALT word is latched into IF/ID with valid = 1, so decode sees it once.
  - PC holds at the HALT address; next state HALT.
- HALT:
  - Every cycle: instruction = NOP_WORD, valid = 0, halted = 1; PC frozen; stall and PCSrc ignored.
  - Only reset exits this state.
- Latency:
  - Fetch-to-IF/ID is 1 cycle.
  - Redirect costs exactly one bubble: the target instruction appears in IF/ID two edges after PCSrc is sampled.
- No combinational path from any input to any output, except imem_data feeding IF/ID through a register.

Optional Feature:
- Macro: IF_STAGE_STATS_EN.
- Defined: adds outputs fetch_count[15:0] and kill_count[15:0], both reset to 0.
  - fetch_count increments on each cycle IF/ID loads valid = 1.
  - kill_count increments on each redirect kill.
  - Both saturate at 16'hFFFF and hold in HALT.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then run, imem returns 16'h1000 + addr, stall = 0, PCSrc = 0:
  - BOOT cycle gives valid = 0.
  - Next edges give instruction = 16'h1000 / NPC = 1, then 16'h1001 / NPC = 2; imem_addr increments 0, 1, 2.
- At PC = 5, assert stall for 3 cycles:
  - imem_addr stays 5; instruction, NPC and valid are unchanged for 3 edges.
  - Fetch resumes with NPC = 6.
- At PC = 8, PCSrc = 1 with I_TypeImmediate = 16'h0040 for one cycle:
  - Next edge: valid = 0, instruction = NOP_WORD, imem_addr = 16'h0040.
  - Following edge: instruction = mem[16'h40], NPC = 16'h0041.
  - Repeat with PCSrc = 2 (J_TypeImmediate = 16'h0123) and PCSrc = 3 (ReturnAddress = 16'h0200).
- Stall = 1 and PCSrc = 1 in the same cycle: no redirect, PC holds. Drop stall with PCSrc still 1: redirect occurs.
- Fetch 16'hF000 at address 3:
  - IF/ID = 16'hF000 with valid = 1, then halted = 1, valid = 0, imem_addr stuck at 3 for 10 cycles.
  - reset returns to BOOT with PC = 0.
- Set PC = 16'hFFFF via ReturnAddress redirect, then sequential fetch: NPC = 16'h0000 and imem_addr wraps to 0.
- With IF_STAGE_STATS_EN defined: after 4 fetches and 1 redirect, fetch_count = 4 and kill_count = 1.
